hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: CLK in 1 (all state on rising edge) and nRST in 1 (asynchronous, active-low).
REQ-002 ihit in 1: instruction fetch completed this cycle.
REQ-003 dhit in 1: data memory access completed this cycle.
REQ-004 dmemREN, dmemWEN in 1 each: MEM-stage data read/write request pending.
REQ-005 exMemToReg, exWEN in 1 each: EX-stage instruction is a load / writes the register file.
REQ-006 exrt in 5: EX-stage load destination register.
REQ-007 idrsel1, idrsel2 in 5 each: ID-stage source registers.
REQ-008 brnch_taken, jmp_taken in 1 each: branch/J/JR/JAL redirect resolved in EX this cycle.
REQ-009 memHALT in 1: halt instruction present in MEM stage.
REQ-010 pcW out 1: PC load enable.
REQ-011 ifidW, ifidRST out 1 each: IF/ID latch enable / bubble select.
REQ-012 idW, idRST out 1 each: ID/EX latch enable / bubble select (drive ID/EX idW, idRST).
REQ-013 exmemW, memwbW out 1 each: EX/MEM, MEM/WB latch enables.
REQ-014 halt out 1: sticky processor halt.
REQ-015 stall_cnt out 16: saturating count of cycles with pcW=0 outside HALTED.

Function
REQ-016 Latch semantics SHALL be: xW=0 -> hold; xW=1, xRST=0 -> load; xW=1, xRST=1 -> load bubble (all zeros).
REQ-017 States SHALL be RUN, MEMWAIT, HALTED; control outputs are combinational from state and inputs, evaluated in this priority order.
REQ-018 HALTED: all W=0, all RST=0, halt=1; exit only via nRST.
REQ-019 mem_busy = (dmemREN|dmemWEN) & ~dhit; when set, all W=0 and all RST=0 (full freeze); next state MEMWAIT.
REQ-020 MEMWAIT: remains while mem_busy; on dhit it applies normal rules in that same cycle; next state RUN.
REQ-021 Redirect (brnch_taken|jmp_taken, not busy): pcW=1; ifidW=ifidRST=1; idW=idRST=1; exmemW=memwbW=1; overrides load-use and ihit=0.
REQ-022 Load-use = exMemToReg & exWEN & exrt!=0 & (exrt==idrsel1 | exrt==idrsel2); when set: pcW=0, ifidW=0, idW=idRST=1, exmemW=memwbW=1, for exactly one cycle (bubble then clears exMemToReg).
REQ-023 Fetch miss (ihit=0, none above): pcW=0; ifidW=ifidRST=1; idW=1, idRST=0; exmemW=memwbW=1.
REQ-024 Normal: all W=1, all RST=0.
REQ-025 memHALT=1 at an edge with state not HALTED: next state HALTED; memHALT has priority over mem_busy.
REQ-026 stall_cnt SHALL increment by 1 per edge when pcW=0 and state!=HALTED, saturating at 16'hFFFF with no wrap.
REQ-027 Register 0 SHALL never cause a load-use stall.

Reset
REQ-028 nRST=0 asynchronously: state=RUN, halt=0, stall_cnt=0; while nRST=0 all W=0 and all RST=0.
REQ-029 After nRST rises, the first edge SHALL evaluate normal rules, with no extra idle cycle.
REQ-030 Reset mid-stall or mid-MEMWAIT SHALL discard pending state; no bubble is inserted after release.

Verification
REQ-031 Load-use: exMemToReg=1, exWEN=1, exrt=5, idrsel2=5, ihit=1 -> one cycle of pcW=0, ifidW=0, idW=idRST=1; then all W=1; stall_cnt=1.
REQ-032 exrt=0 with the same load -> no stall, all W=1.
REQ-033 dmemREN=1, dhit=0 for 3 cycles, then dhit=1 -> 3 cycles of all W=0 (MEMWAIT), all W=1 in the dhit cycle; stall_cnt=3.
REQ-034 brnch_taken=1 coincident with load-use and ihit=0 -> pcW=1, ifidRST=1, idRST=1, stall_cnt unchanged.
REQ-035 memHALT=1 coincident with mem_busy -> next cycle halt=1, all W=0, held until nRST=0 clears to halt=0, stall_cnt=0.
REQ-036 Force stall_cnt to 16'hFFFF via a long ihit=0 stream -> stays at 16'hFFFF.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: freezes on data-memory waits, bubbles on load-use,
// flushes on redirects, and holds the machine in a sticky halt until reset.
module hazard_unit (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic        exMemToReg,
  input  logic        exWEN,
  input  logic [4:0]  exrt,
  input  logic [4:0]  idrsel1,
  input  logic [4:0]  idrsel2,
  input  logic        brnch_taken,
  input  logic        jmp_taken,
  input  logic        memHALT,
  output logic        pcW,
  output logic        ifidW,
  output logic        ifidRST,
  output logic        idW,
  output logic        idRST,
  output logic        exmemW,
  output logic        memwbW,
  output logic        halt,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MEMWAIT, HALTED} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_halt;
  logic [15:0] r_stall_cnt;
  logic        w_mem_busy;
  logic        w_redirect;
  logic        w_load_use;

  assign w_mem_busy = (dmemREN | dmemWEN) & ~dhit;
  assign w_redirect = brnch_taken | jmp_taken;
  // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign w_load_use = exMemToReg & exWEN & (exrt != 5'd0) &
                      ((exrt == idrsel1) | (exrt == idrsel2));

  // NOTE: every output gets a default first so no path through the priority chain infers a latch.
  always_comb begin
    pcW     = 1'b0;
    ifidW   = 1'b0;
    ifidRST = 1'b0;
    idW     = 1'b0;
    idRST   = 1'b0;
    exmemW  = 1'b0;
    memwbW  = 1'b0;
    if (!nRST || r_state == HALTED || w_mem_busy) begin
      // full freeze: defaults already hold every latch
    end else if (w_redirect) begin
      pcW     = 1'b1;
      ifidW   = 1'b1;
      ifidRST = 1'b1;
      idW     = 1'b1;
      idRST   = 1'b1;
      exmemW  = 1'b1;
      memwbW  = 1'b1;
    end else if (w_load_use) begin
      idW     = 1'b1;
      idRST   = 1'b1;
      exmemW  = 1'b1;
      memwbW  = 1'b1;
    end else if (!ihit) begin
      ifidW   = 1'b1;
      ifidRST = 1'b1;
      idW     = 1'b1;
      exmemW  = 1'b1;
      memwbW  = 1'b1;
    end else begin
      pcW     = 1'b1;
      ifidW   = 1'b1;
      idW     = 1'b1;
      exmemW  = 1'b1;
      memwbW  = 1'b1;
    end
  end

  // A halt reaching MEM wins even over a pending memory wait.
  always_comb begin
    w_next = RUN;
    if (r_state == HALTED || memHALT)
      w_next = HALTED;
    else if (w_mem_busy)
      w_next = MEMWAIT;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= RUN;
      r_halt      <= 1'b0;
      r_stall_cnt <= 16'd0;
    end else begin
      r_state <= w_next;
      r_halt  <= (w_next == HALTED);
      if (!pcW && r_state != HALTED && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign halt      = r_halt;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_unit;

  // {pcW, ifidW, ifidRST, idW, idRST, exmemW, memwbW}
  localparam logic [6:0] FRZ   = 7'b0000000;
  localparam logic [6:0] NORM  = 7'b1101011;
  localparam logic [6:0] REDIR = 7'b1111111;
  localparam logic [6:0] LDUSE = 7'b0001111;
  localparam logic [6:0] FMISS = 7'b0111011;

  typedef struct {
    string       name;
    logic [6:0]  ctrl;
    logic        halt;
    logic [15:0] cnt;
  } exp_t;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, dmemREN, dmemWEN, exMemToReg, exWEN;
  logic [4:0]  exrt, idrsel1, idrsel2;
  logic        brnch_taken, jmp_taken, memHALT;
  logic        pcW, ifidW, ifidRST, idW, idRST, exmemW, memwbW, halt;
  logic [15:0] stall_cnt;

  exp_t        sb_q[$];
  logic [15:0] exp_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  hazard_unit dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .exMemToReg(exMemToReg), .exWEN(exWEN),
    .exrt(exrt), .idrsel1(idrsel1), .idrsel2(idrsel2),
    .brnch_taken(brnch_taken), .jmp_taken(jmp_taken), .memHALT(memHALT),
    .pcW(pcW), .ifidW(ifidW), .ifidRST(ifidRST), .idW(idW), .idRST(idRST),
    .exmemW(exmemW), .memwbW(memwbW), .halt(halt), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [6:0] got_ctrl, input logic got_halt,
                       input logic [15:0] got_cnt, input exp_t e);
    n_tests++;
    if (got_ctrl !== e.ctrl || got_halt !== e.halt || got_cnt !== e.cnt) begin
      n_fail++;
      $display("FAIL %s: got ctrl=%b halt=%b cnt=%h, expected ctrl=%b halt=%b cnt=%h",
               name, got_ctrl, got_halt, got_cnt, e.ctrl, e.halt, e.cnt);
    end
  endtask

  always @(negedge CLK) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check(e.name, {pcW, ifidW, ifidRST, idW, idRST, exmemW, memwbW}, halt, stall_cnt, e);
    end
  end

  task automatic set_in(input logic ih, input logic dh, input logic ren, input logic wen,
                        input logic mtr, input logic xw, input logic [4:0] rt,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic br, input logic jp, input logic mh);
    ihit = ih; dhit = dh; dmemREN = ren; dmemWEN = wen; exMemToReg = mtr; exWEN = xw;
    exrt = rt; idrsel1 = rs1; idrsel2 = rs2; brnch_taken = br; jmp_taken = jp; memHALT = mh;
  endtask

  task automatic set_idle();
    set_in(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
  endtask

  // Queue the expectation for the current cycle, then advance to just past the next edge.
  task automatic step(input string name, input logic [6:0] ctrl, input logic hlt);
    exp_t e;
    e.name = name; e.ctrl = ctrl; e.halt = hlt; e.cnt = exp_cnt;
    sb_q.push_back(e);
    @(posedge CLK);
    if (nRST && !ctrl[6] && !hlt && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    exp_cnt = 16'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    do_reset();
    @(posedge CLK); #1;
    step("reset_state", FRZ, 0);
    nRST = 1'b1;
    step("first_after_reset", NORM, 0);

    // load-use on rs2, bubble clears exMemToReg next cycle
    set_in(1, 0, 0, 0, 1, 1, 5'd5, 5'd0, 5'd5, 0, 0, 0);
    step("lduse_rs2", LDUSE, 0);
    set_idle();
    step("lduse_release", NORM, 0);
    set_in(1, 0, 0, 0, 1, 1, 5'd7, 5'd7, 5'd3, 0, 0, 0);
    step("lduse_rs1", LDUSE, 0);
    set_idle();
    step("lduse_rs1_release", NORM, 0);
    set_in(1, 0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step("lduse_r0", NORM, 0);
    set_in(1, 0, 0, 0, 1, 0, 5'd5, 5'd0, 5'd5, 0, 0, 0);
    step("load_no_wen", NORM, 0);

    // data-memory wait: three frozen cycles then release on dhit
    set_in(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step("memwait_1", FRZ, 0);
    step("memwait_2", FRZ, 0);
    step("memwait_3", FRZ, 0);
    dhit = 1'b1;
    step("memwait_dhit", NORM, 0);
    set_idle();
    step("after_memwait", NORM, 0);

    // write wait, then dhit cycle coincides with a load-use
    set_in(1, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step("wr_wait", FRZ, 0);
    set_in(1, 1, 0, 1, 1, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0);
    step("dhit_lduse", LDUSE, 0);

    // redirects override load-use and fetch miss; memory wait overrides redirect
    set_in(0, 0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0);
    step("branch_over_lduse", REDIR, 0);
    set_in(0, 0, 0, 0, 1, 1, 5'd5, 5'd0, 5'd5, 0, 1, 0);
    step("jump_over_lduse", REDIR, 0);
    set_in(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    step("busy_over_branch", FRZ, 0);

    set_in(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step("fetch_miss_1", FMISS, 0);
    step("fetch_miss_2", FMISS, 0);

    // reset in the middle of a memory wait discards it
    set_in(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step("pre_rst_wait", FRZ, 0);
    do_reset();
    step("rst_mid_wait", FRZ, 0);
    nRST = 1'b1;
    set_idle();
    step("post_rst_wait", NORM, 0);

    // reset in the middle of a load-use stall inserts no bubble afterwards
    set_in(1, 0, 0, 0, 1, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0);
    step("pre_rst_lduse", LDUSE, 0);
    do_reset();
    step("rst_mid_lduse", FRZ, 0);
    nRST = 1'b1;
    set_idle();
    step("post_rst_lduse", NORM, 0);

    // halt beats a pending memory wait and sticks until reset
    set_in(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    step("halt_with_busy", FRZ, 0);
    set_in(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    step("halted_1", FRZ, 1);
    step("halted_2", FRZ, 1);
    set_idle();
    step("halted_3", FRZ, 1);
    do_reset();
    step("halt_cleared", FRZ, 0);
    nRST = 1'b1;
    step("run_after_halt", NORM, 0);

    // saturation: 65535 stall edges from zero bring the counter to its ceiling
    do_reset();
    @(posedge CLK); #1;
    nRST = 1'b1;
    ihit = 1'b0;
    repeat (65535) @(posedge CLK);
    #1;
    exp_cnt = 16'hFFFF;
    step("sat_reached", FMISS, 0);
    step("sat_held", FMISS, 0);
    ihit = 1'b1;
    step("sat_normal", NORM, 0);

    @(negedge CLK); #1;
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
